// File: rtl/dm_mem_mmio_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg : shared types, MMIO offsets and load-extension helper for dm_mem_mmio
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    localparam logic [31:0] LED_OFS = 32'd0;
    localparam logic [31:0] SW_OFS  = 32'd4;

    // Selects the addressed byte/half of a word and sign- or zero-extends it.
    function automatic logic [31:0] dm_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  ctrl);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (ctrl)
            DM_B:    r = {{24{b[7]}}, b};
            DM_H:    r = {{16{h[15]}}, h};
            DM_BU:   r = {24'd0, b};
            DM_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_mem_mmio_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser for asynchronous level inputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/dm_mem_mmio.sv
// ---------------------------------------------------------------------------
// dm_mem_mmio : byte-addressable data RAM with LED/switch MMIO, valid-ready
//               request/response handshake and one-cycle read latency
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_mem_mmio
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_ctrl,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] leds
);

    localparam int          c_words     = 2 ** (ADDR_W - 2);
    localparam logic [31:0] c_ram_bytes = 32'(2 ** ADDR_W);
    localparam logic [31:0] c_led_addr  = MMIO_BASE + LED_OFS;
    localparam logic [31:0] c_sw_addr   = MMIO_BASE + SW_OFS;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e        r_state;
    logic [31:0]       r_mem [c_words];
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;
    logic [LED_W-1:0]  r_leds;

    logic [SW_W-1:0]   w_sw_sync;
    logic              w_accept;
    logic              w_is_ram;
    logic              w_is_led;
    logic              w_is_sw;
    logic              w_legal;
    logic              w_misalign;
    logic              w_err;
    logic              w_ram_we;
    logic              w_led_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_rd_word;
    logic [ADDR_W-3:0] w_idx;
    logic [LED_W-1:0]  w_led_mask;
    logic [LED_W-1:0]  w_led_next;

    sync_2ff #(.W(SW_W)) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw),
        .q     (w_sw_sync)
    );

    assign rsp_valid = (r_state == S_FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    // Gating with rst_n keeps a request presented during reset from writing RAM.
    assign w_accept  = rst_n && req_valid && req_ready;

    assign w_idx    = req_addr[ADDR_W-1:2];
    assign w_is_ram = (req_addr < c_ram_bytes);
    assign w_is_led = (req_addr == c_led_addr);
    assign w_is_sw  = (req_addr == c_sw_addr);

    always_comb begin
        w_legal     = 1'b1;
        w_misalign  = 1'b0;
        w_be        = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_ctrl)
            DM_B, DM_BU: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            DM_H, DM_HU: begin
                w_misalign  = req_addr[0];
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            DM_W: begin
                w_misalign  = |req_addr[1:0];
                w_be        = 4'b1111;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ctrl[2] marks the unsigned variants, which are load-only.
    assign w_err = !w_legal || w_misalign || !(w_is_ram || w_is_led || w_is_sw)
                   || (req_we && (req_ctrl[2] || w_is_sw));

    assign w_ram_we = w_accept && req_we && !w_err && w_is_ram;
    assign w_led_we = w_accept && req_we && !w_err && w_is_led;

    for (genvar g = 0; g < LED_W; g++) begin : g_led_mask
        assign w_led_mask[g] = w_be[g / 8];
    end

    assign w_led_next = (r_leds & ~w_led_mask) | (w_wdata_rep[LED_W-1:0] & w_led_mask);

    always_comb begin
        w_rd_word = r_mem[w_idx];
        if (w_is_led) begin
            w_rd_word = 32'(r_leds);
        end else if (w_is_sw) begin
            w_rd_word = 32'(w_sw_sync);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            if (w_be[0]) r_mem[w_idx][7:0]   <= w_wdata_rep[7:0];
            if (w_be[1]) r_mem[w_idx][15:8]  <= w_wdata_rep[15:8];
            if (w_be[2]) r_mem[w_idx][23:16] <= w_wdata_rep[23:16];
            if (w_be[3]) r_mem[w_idx][31:24] <= w_wdata_rep[31:24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_leds     <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (rsp_ready && !w_accept) r_state <= S_EMPTY;
            endcase
            if (w_accept) begin
                r_rsp_err  <= w_err;
                r_rsp_data <= (w_err || req_we) ? 32'd0
                              : dm_extend(w_rd_word, req_addr[1:0], req_ctrl);
            end
            if (w_led_we) begin
                r_leds <= w_led_next;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;
    assign leds     = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_dm_mem_mmio.sv
// ---------------------------------------------------------------------------
// tb_dm_mem_mmio : directed scoreboard bench for dm_mem_mmio
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dm_mem_mmio;
    import dm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [9:0]  sw;
    logic [9:0]  leds;

    typedef struct packed {
        logic        e;
        logic [31:0] d;
    } sb_t;

    sb_t sb[$];
    sb_t m_ent;
    int  checks = 0;
    int  errors = 0;
    int  n_rsp  = 0;
    int  last_wait;

    dm_mem_mmio #(
        .ADDR_W    (10),
        .LED_W     (10),
        .SW_W      (10),
        .MMIO_BASE (32'h0000_0400)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sw        (sw),
        .leds      (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: compares each consumed response with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                m_ent = sb.pop_front();
                chk($sformatf("rsp_data#%0d", n_rsp), rsp_data, m_ent.d);
                chk($sformatf("rsp_err#%0d", n_rsp), 32'(rsp_err), 32'(m_ent.e));
                n_rsp++;
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        last_wait = n;
        chk("accept_timeout", 32'(req_ready), 32'd1);
        if (req_ready) sb.push_back('{e: exp_e, d: exp_d});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_ctrl  = 3'b000;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b1;
        sw        = 10'd0;
        last_wait = 0;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_leds",      32'(leds),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAM word store and extended loads
        send(1'b1, DM_W,  32'h010, 32'hDEADBEEF, 32'h0,        1'b0);
        send(1'b0, DM_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        send(1'b0, DM_B,  32'h013, 32'h0,        32'hFFFFFFDE, 1'b0);
        send(1'b0, DM_BU, 32'h013, 32'h0,        32'h000000DE, 1'b0);
        send(1'b0, DM_H,  32'h012, 32'h0,        32'hFFFFDEAD, 1'b0);
        send(1'b0, DM_HU, 32'h010, 32'h0,        32'h0000BEEF, 1'b0);

        // Byte store leaves the other lanes alone
        send(1'b1, DM_B,  32'h011, 32'h00000055, 32'h0,        1'b0);
        send(1'b0, DM_W,  32'h010, 32'h0,        32'hDEAD55EF, 1'b0);

        // Faulting requests, then confirm RAM untouched
        send(1'b0, DM_H,  32'h001, 32'h0,        32'h0,        1'b1);
        send(1'b0, DM_W,  32'h006, 32'h0,        32'h0,        1'b1);
        send(1'b0, 3'b011, 32'h010, 32'h0,       32'h0,        1'b1);
        send(1'b0, DM_W,  32'h800, 32'h0,        32'h0,        1'b1);
        send(1'b1, DM_HU, 32'h010, 32'h00001234, 32'h0,        1'b1);
        send(1'b1, DM_W,  32'h008, 32'h11111111, 32'h0,        1'b0);
        send(1'b1, DM_W,  32'h402, 32'h11111111, 32'h0,        1'b1);
        send(1'b0, DM_W,  32'h010, 32'h0,        32'hDEAD55EF, 1'b0);
        drain();

        // LED register: word, byte and half stores
        send(1'b1, DM_W,  32'h400, 32'h000003FF, 32'h0,        1'b0);
        chk("leds_word", 32'(leds), 32'h3FF);
        send(1'b1, DM_B,  32'h400, 32'h00000080, 32'h0,        1'b0);
        chk("leds_byte", 32'(leds), 32'h380);
        send(1'b0, DM_B,  32'h400, 32'h0,        32'hFFFFFF80, 1'b0);
        send(1'b0, DM_W,  32'h400, 32'h0,        32'h00000380, 1'b0);
        send(1'b1, DM_H,  32'h400, 32'h0000ABCD, 32'h0,        1'b0);
        chk("leds_half", 32'(leds), 32'h3CD);

        // Switch register through the synchroniser
        sw = 10'h2AA;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send(1'b0, DM_HU, 32'h404, 32'h0,        32'h000002AA, 1'b0);
        send(1'b1, DM_W,  32'h404, 32'h00000001, 32'h0,        1'b1);
        drain();
        chk("leds_after_sw_store", 32'(leds), 32'h3CD);

        // Backpressure: response held, second request blocked
        rsp_ready = 1'b0;
        send(1'b0, DM_W, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_ctrl  = DM_B;
        req_addr  = 32'h013;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_data%0d", i),  rsp_data,       32'hDEAD55EF);
            chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        sb.push_back('{e: 1'b0, d: 32'hFFFFFFDE});
        @(posedge clk);
        #1;
        chk("b2b_valid0", 32'(rsp_valid), 32'd1);
        send(1'b0, DM_BU, 32'h013, 32'h0, 32'h000000DE, 1'b0);
        chk("b2b_wait1", 32'(last_wait), 32'd0);
        send(1'b0, DM_HU, 32'h010, 32'h0, 32'h000055EF, 1'b0);
        chk("b2b_wait2", 32'(last_wait), 32'd0);
        send(1'b0, DM_W,  32'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        chk("b2b_wait3", 32'(last_wait), 32'd0);
        chk("b2b_valid3", 32'(rsp_valid), 32'd1);
        drain();

        // Reset while a response is pending and a store is presented
        rsp_ready = 1'b0;
        send(1'b0, DM_W, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = DM_W;
        req_addr  = 32'h010;
        req_wdata = 32'h12345678;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("mid_rst_rsp_data",  rsp_data,       32'd0);
        chk("mid_rst_leds",      32'(leds),      32'd0);
        sb.delete();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, DM_W, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_mem_mmio.md
Name: dm_mem_mmio

Overview:
- Clocked, parametrised successor to the single-cycle data memory.
- Byte-addressable RAM organised as 32-bit words with per-byte write enables.
- Memory-mapped LED output register and synchronised switch input register.
- Request/response valid-ready handshake with one-cycle read latency, response backpressure, and an error flag for misaligned, illegal or out-of-range accesses.

Parameters:
- ADDR_W, 10, byte-address width of RAM; RAM holds 2**ADDR_W bytes (2**(ADDR_W-2) words).
- LED_W, 10, width of LED output register.
- SW_W, 10, width of switch input.
- MMIO_BASE, 32'h0000_0400, byte address of the LED register. The switch register is at MMIO_BASE+4. MMIO_BASE must be at or above 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  access faulted.
- sw  in  SW_W  asynchronous board switches.
- leds  out  LED_W  LED register value.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rsp_valid=0, rsp_data=0, rsp_err=0, leds=0, switch synchroniser flops=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction drops any pending response; no partial write occurs after reset asserts.
- Handshake and latency:
  - req_ready = !rsp_valid || rsp_ready.
  - This is a one-entry output buffer; back-to-back requests sustain one per cycle when rsp_ready=1.
  - On accept at edge N, rsp_valid=1 from N+1.
  - rsp_data, rsp_err and rsp_valid hold stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on the consuming edge unless a new request is accepted on that same edge.
- Response FSM:
  - States: EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on consume+accept.
  - FULL -> EMPTY on consume without accept.
  - FULL holds when !rsp_ready.
- Alignment:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU have no alignment requirement.
- Decode:
  - addr < 2**ADDR_W selects RAM.
  - addr == MMIO_BASE selects LED.
  - addr == MMIO_BASE+4 selects SW.
  - Any other address is out of range.
- Errors:
  - Misaligned, illegal ctrl, out-of-range, store with BU/HU, or store to SW → rsp_err=1, rsp_data=0.
  - An erroring request performs no RAM or LED side effect.
- RAM stores:
  - Commit on the accept edge.
  - Byte enables: B → 1 lane at addr[1:0]; H → lanes addr[1]*2 and +1; W → all 4 lanes.
  - Store data is replicated across the lanes so the low bytes land in the enabled lanes.
  - Bit slicing uses exact byte boundaries [7:0], [15:8], [23:16], [31:24].
- RAM loads:
  - Word read at addr[ADDR_W-1:2] is captured on the accept edge.
  - Byte or half is selected by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
  - A load after a store to the same address on the previous accepted request returns the new data.
- LED register:
  - Word store → leds <= wdata[LED_W-1:0].
  - Byte or half store updates only the enabled lanes that fall within LED_W.
  - Loads return leds zero-extended, then width-extended per ctrl.
- Switch register:
  - sw passes through a 2-flop synchroniser.
  - Loads return the synchronised value zero-extended, then per ctrl.
  - Latency from sw change to a readable value: 2 cycles.
- Address bits above ADDR_W are ignored only for the RAM index; they still participate in range decode.

Decomposition:
- Package dm_pkg:
  - dm_ctrl_e enum with DM_B, DM_H, DM_W, DM_BU, DM_HU.
  - Default MMIO offsets as localparams LED_OFS=0 and SW_OFS=4.
  - Function dm_extend(word, addr_lo, ctrl) returning the aligned, extended load value.
- Sub-module sync_2ff #(W): two-flop synchroniser with asynchronous active-low reset, used for sw.
- RAM is inferred inside dm_mem_mmio as a word array with byte-enable writes.

Test Plan:
- Store W 32'hDEADBEEF at 0x010, then loads: W 0x010 → 32'hDEADBEEF; B 0x013 → 32'hFFFFFFDE; BU 0x013 → 32'h000000DE; H 0x012 → 32'hFFFFDEAD; HU 0x010 → 32'h0000BEEF.
- Store B 8'h55 at 0x011 over the previous word; load W 0x010 → 32'hDEAD55EF, confirming the other lanes are untouched.
- Misaligned H at 0x001, W at 0x006, ctrl=3'b011, addr 0x800, and store with HU → each rsp_err=1 and rsp_data=0; a follow-up load W 0x010 shows RAM unchanged.
- Store W 32'h3FF to MMIO_BASE → leds=10'h3FF on the next cycle. Then set sw=10'h2AA, wait 2 cycles, load HU MMIO_BASE+4 → 32'h000002AA. Store to MMIO_BASE+4 → rsp_err=1, leds unchanged.
- Hold rsp_ready=0 for 3 cycles after a load: rsp_valid stays 1, data stable, req_ready=0, a second request is not accepted. Raise rsp_ready with req_valid held: back-to-back accept, one response per cycle thereafter.
- Assert rst_n=0 while rsp_valid=1 and a store is presented: rsp_valid, rsp_err, rsp_data and leds go to 0 immediately; after release the first load sees RAM without the dropped store.
